// File: rtl/cmd_packetizer.sv
// Host-side command packetizer: queues parallel commands in a small FIFO and
// serialises each one into a fixed UART byte frame, optionally closed by an XOR checksum.
module cmd_packetizer #(
  parameter int DEPTH  = 4,
  parameter int CHK_EN = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  dtype,
  input  logic [4:0]  op,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [2:0] LAST_IDX = (CHK_EN != 0) ? 3'd6 : 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, WAIT = 2'd3} state_e;

  // Entry layout is {dtype[40:37], op[36:32], src1[31:16], src2[15:0]}.
  function automatic logic [7:0] checksum(input logic [40:0] e);
    return {3'b000, e[36:32]} ^ {4'b0000, e[40:37]} ^ e[31:24] ^ e[23:16] ^ e[15:8] ^ e[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [40:0] e, input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = {3'b000, e[36:32]};
      3'd1:    b = {4'b0000, e[40:37]};
      3'd2:    b = e[31:24];
      3'd3:    b = e[23:16];
      3'd4:    b = e[15:8];
      3'd5:    b = e[7:0];
      3'd6:    b = checksum(e);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [40:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [40:0]   frame_q, frame_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          push_s, pop_s, empty_s, full_s;
  logic [40:0]   head_s;

  assign empty_s    = (count_q == {CW{1'b0}});
  assign full_s     = (count_q == FULL_CNT);
  assign cmd_ready  = ~full_s;
  assign push_s     = cmd_valid & ~full_s;
  assign head_s     = mem_q[rd_ptr_q];
  assign busy       = (state_q != IDLE) | ~empty_s;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_done = frame_done_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1'b1);
    end else if (!push_s && pop_s) begin
      count_d = count_q - CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage and pointers; reset discards every queued command
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 41'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= {dtype, op, src1, src2};
      end
    end
  end

  // Frame sequencer: next state and registered-output next values
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    pop_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        frame_d    = head_s;
        pop_s      = 1'b1;
        idx_d      = 3'd0;
        tx_valid_d = 1'b1;
        tx_data_d  = frame_byte(head_s, 3'd0);
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done && (idx_q == LAST_IDX)) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else if (tx_done) begin
          idx_d      = idx_q + 3'd1;
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(frame_q, idx_q + 3'd1);
          state_d    = SEND;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; tx_valid is high exactly in SEND
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      frame_q      <= 41'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_cmd_packetizer.sv
// Self-checking bench for cmd_packetizer: directed scenarios plus random traffic,
// checked against a byte-queue reference model built from accepted commands.
module tb_cmd_packetizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst, cmd_valid, cmd_ready, tx_valid, busy, frame_done;
  logic        tx_done_u, spur, tx_done_in;
  logic [3:0]  dtype;
  logic [4:0]  op;
  logic [15:0] src1, src2;
  logic [7:0]  tx_data;
  logic        cmd_valid0, cmd_ready0, tx_valid0, tx_done0, busy0, frame_done0;
  logic [7:0]  tx_data0;

  assign tx_done_in = tx_done_u | spur;

  cmd_packetizer #(.DEPTH(4), .CHK_EN(1)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .dtype(dtype), .op(op), .src1(src1), .src2(src2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done_in),
    .busy(busy), .frame_done(frame_done));

  cmd_packetizer #(.DEPTH(4), .CHK_EN(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .dtype(dtype), .op(op), .src1(src1), .src2(src2),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_done(tx_done0),
    .busy(busy0), .frame_done(frame_done0));

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];
  logic [7:0] got_q [$];
  int tv_cnt = 0;
  int fd_cnt = 0;
  bit in_flight = 1'b0, cur_last = 1'b0, fd_exp = 1'b0, fd_nx = 1'b0;
  bit uart_en = 1'b1;
  int uart_dly = 10;
  bit pend = 1'b0;
  int cnt = 0;
  logic [8:0] e;
  logic [7:0] ref1 [7] = '{8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hDA};
  logic [7:0] ref0 [6] = '{8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'hFF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is the op, dtype, the four operand bytes and their XOR.
  task automatic model_push(input logic [3:0] d, input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
    int by [7];
    by[0] = int'(o);
    by[1] = int'(d);
    by[2] = int'(a) / 256;
    by[3] = int'(a) % 256;
    by[4] = int'(b) / 256;
    by[5] = int'(b) % 256;
    by[6] = by[0] ^ by[1] ^ by[2] ^ by[3] ^ by[4] ^ by[5];
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({(i == 6) ? 1'b1 : 1'b0, by[i][7:0]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cmd();
    dtype = 4'($urandom);
    op    = 5'($urandom);
    src1  = 16'($urandom);
    src2  = 16'($urandom);
  endtask

  task automatic drain(input string tag, input int limit);
    int t;
    t = 0;
    while ((busy || in_flight || exp_q.size() != 0) && t < limit) begin
      step();
      t++;
    end
    check(tag, (t < limit), 1'b1);
    repeat (2) step();
  endtask

  // Monitor: byte order, frame_done timing and accepted-command tracking
  always @(negedge clk) begin
    check("frame_done", frame_done, fd_exp);
    if (!n_rst) begin
      in_flight = 1'b0;
      fd_exp    = 1'b0;
    end else begin
      fd_nx = 1'b0;
      if (tx_valid) begin
        tv_cnt++;
        got_q.push_back(tx_data);
        check("byte_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e[7:0]);
          cur_last = e[8];
        end
        in_flight = 1'b1;
      end else if (tx_done_in && in_flight) begin
        in_flight = 1'b0;
        fd_nx     = cur_last;
      end
      fd_exp = fd_nx;
      if (frame_done) fd_cnt++;
      if (cmd_valid && cmd_ready) model_push(dtype, op, src1, src2);
    end
  end

  // UART model: acknowledges each byte uart_dly cycles after its tx_valid
  initial begin
    tx_done_u = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_done_u = 1'b0;
      if (!n_rst) begin
        pend = 1'b0;
      end else if (tx_valid) begin
        pend = 1'b1;
        cnt  = 0;
      end else if (pend && uart_en) begin
        cnt++;
        if (cnt >= uart_dly) begin
          tx_done_u = 1'b1;
          pend      = 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, lat, tv0, fdc0, acc, n0;
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_valid0 = 1'b0; tx_done0 = 1'b0; spur = 1'b0;
    dtype = 4'h0; op = 5'h00; src1 = 16'h0000; src2 = 16'h0000;
    repeat (3) step();
    n_rst = 1'b1;
    step();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_cmd_ready0", cmd_ready0, 1'b1);

    // Single command with checksum
    uart_dly = 10; got_q.delete(); tv0 = tv_cnt; fdc0 = fd_cnt;
    dtype = 4'h1; op = 5'h02; src1 = 16'h1234; src2 = 16'h00FF; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat = 1;
    while (!tx_valid && lat < 10) begin
      step();
      lat++;
    end
    check("latency_b0", lat, 3);
    drain("drain_single", 400);
    check("single_nbytes", got_q.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < got_q.size()) check("single_byte", got_q[k], ref1[k]);
    end
    check("single_tv_pulses", tv_cnt - tv0, 7);
    check("single_fd_pulses", fd_cnt - fdc0, 1);
    check("single_busy_end", busy, 1'b0);

    // Same command without checksum
    cmd_valid0 = 1'b1;
    step();
    cmd_valid0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      t = 0;
      while (!tx_valid0 && t < 20) begin
        step();
        t++;
      end
      check("c0_valid", tx_valid0, 1'b1);
      check("c0_byte", tx_data0, ref0[k]);
      repeat (3) step();
      tx_done0 = 1'b1;
      step();
      tx_done0 = 1'b0;
      check("c0_frame_done", frame_done0, (k == 5));
    end
    n0 = 0;
    repeat (10) begin
      step();
      if (tx_valid0) n0++;
    end
    check("c0_no_7th_byte", n0, 0);
    check("c0_busy_end", busy0, 1'b0);

    // Spurious tx_done while idle
    tv0 = tv_cnt; fdc0 = fd_cnt;
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    check("spur_idle_busy", busy, 1'b0);
    check("spur_idle_tv", tv_cnt - tv0, 0);
    check("spur_idle_fd", fd_cnt - fdc0, 0);

    // Spurious tx_done in the SEND cycle
    rand_cmd(); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    t = 0;
    while (!tx_valid && t < 10) begin
      step();
      t++;
    end
    check("spur_send_b0", tx_valid, 1'b1);
    spur = 1'b1;
    step();
    spur = 1'b0;
    t = 1;
    while (!tx_valid && t < 50) begin
      step();
      t++;
    end
    check("spur_send_gap", t, 11);
    drain("drain_spur", 400);

    // Fill with the UART stalled, then a push attempt across a LOAD pop while full
    uart_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_cmd(); cmd_valid = 1'b1;
      step();
    end
    check("full_after_5", cmd_ready, 1'b0);
    repeat (3) begin
      rand_cmd();
      step();
      check("full_hold", cmd_ready, 1'b0);
    end
    uart_en = 1'b1;
    t = 0;
    while (!frame_done && t < 300) begin
      rand_cmd();
      step();
      t++;
    end
    check("fill_fd_seen", frame_done, 1'b1);
    check("ready_idle_full", cmd_ready, 1'b0);
    rand_cmd();
    step();
    check("ready_load_full", cmd_ready, 1'b0);
    rand_cmd();
    step();
    check("ready_after_pop", cmd_ready, 1'b1);
    rand_cmd();
    step();
    check("ready_refull", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    drain("drain_fill", 1500);

    // Random traffic with random UART latency
    for (int n = 0; n < 25; n++) begin
      uart_dly = $urandom_range(1, 6);
      repeat ($urandom_range(0, 3)) step();
      rand_cmd(); cmd_valid = 1'b1;
      t = 0;
      do begin
        acc = cmd_ready;
        step();
        t++;
      end while (!acc && t < 500);
      cmd_valid = 1'b0;
      check("rand_accept", acc, 1'b1);
    end
    drain("drain_random", 3000);

    // Reset in WAIT after B3 with two commands still queued
    uart_dly = 10; tv0 = tv_cnt;
    for (int i = 0; i < 3; i++) begin
      rand_cmd(); cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    t = 0;
    while (tv_cnt < tv0 + 4 && t < 300) begin
      step();
      t++;
    end
    check("rst_b3_sent", tv_cnt - tv0, 4);
    n_rst = 1'b0;
    exp_q.delete();
    step();
    n_rst = 1'b1;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    tv0 = tv_cnt;
    repeat (40) step();
    check("midrst_no_bytes", tv_cnt - tv0, 0);
    check("midrst_busy_idle", busy, 1'b0);
    rand_cmd(); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    drain("drain_after_rst", 400);
    check("post_rst_frame", tv_cnt - tv0, 7);
    check("model_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
